// File: rtl/opponent_punch_ctrl_if.sv
// Player/LFSR-facing signal bundle of the opponent punch sequencer.
// The slave modport is the sequencer; the master modport is the game/LFSR/input side.
interface opponent_punch_ctrl_if;
   logic       game_active;
   logic       random_pos;
   logic       dodge_left;
   logic       dodge_right;
   logic       block;
   logic       lfsr_enable;
   logic       wind_up;
   logic       punch_side;
   logic       punch_left;
   logic       punch_right;
   logic       player_hit;
   logic       punch_dodged;
   logic       punch_blocked;
   logic [3:0] hits_taken;
   logic       ko;

   modport slave (
      input  game_active, random_pos, dodge_left, dodge_right, block,
      output lfsr_enable, wind_up, punch_side, punch_left, punch_right,
             player_hit, punch_dodged, punch_blocked, hits_taken, ko
   );

   modport master (
      output game_active, random_pos, dodge_left, dodge_right, block,
      input  lfsr_enable, wind_up, punch_side, punch_left, punch_right,
             player_hit, punch_dodged, punch_blocked, hits_taken, ko
   );
endinterface

// File: rtl/opponent_punch_ctrl.sv
// Opponent punch sequencer: WAIT -> SAMPLE -> WINDUP -> STRIKE -> RECOVER, judging the player response.
// Latency: first punch sampled IDLE_CYCLES+1 cycles after start; no backpressure, all outputs are Moore/registered.
module opponent_punch_ctrl #(
   parameter int CNT_W          = 26,
   parameter int IDLE_CYCLES    = 25000000,
   parameter int WINDUP_CYCLES  = 15000000,
   parameter int RECOVER_CYCLES = 10000000,
   parameter int MAX_HITS       = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   opponent_punch_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_SAMPLE, S_WINDUP, S_STRIKE, S_RECOVER, S_KO
   } state_t;

   localparam logic [CNT_W-1:0] IDLE_LD    = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WINDUP_LD  = CNT_W'(WINDUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYCLES - 1);
   localparam logic [3:0]       MAX_H      = 4'(MAX_HITS);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             side_q, side_d;
   logic [3:0]       hits_q, hits_d;
   logic             hit_q, hit_d;
   logic             dodged_q, dodged_d;
   logic             blocked_q, blocked_d;
   logic             cnt_zero;
   logic             good_dodge;

   assign cnt_zero   = (cnt_q == '0);
   // A punch is escaped by moving away from it, with only that one direction held.
   assign good_dodge = side_q ? (bus.dodge_left & ~bus.dodge_right)
                              : (bus.dodge_right & ~bus.dodge_left);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      side_d    = side_q;
      hits_d    = hits_q;
      hit_d     = 1'b0;
      dodged_d  = 1'b0;
      blocked_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.game_active) begin
               hits_d  = '0;
               cnt_d   = IDLE_LD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!bus.game_active) state_d = S_IDLE;
            else if (cnt_zero)    state_d = S_SAMPLE;
            else                  cnt_d   = cnt_q - 1'b1;
         end
         S_SAMPLE: begin
            side_d  = bus.random_pos;
            cnt_d   = WINDUP_LD;
            state_d = bus.game_active ? S_WINDUP : S_IDLE;
         end
         S_WINDUP: begin
            if (!bus.game_active) state_d = S_IDLE;
            else if (cnt_zero)    state_d = S_STRIKE;
            else                  cnt_d   = cnt_q - 1'b1;
         end
         S_STRIKE: begin
            cnt_d   = RECOVER_LD;
            state_d = S_RECOVER;
            if (bus.block) begin
               blocked_d = 1'b1;
            end else if (good_dodge) begin
               dodged_d = 1'b1;
            end else begin
               hit_d = 1'b1;
               if (hits_q < MAX_H) hits_d = hits_q + 4'd1;
               if (hits_q + 4'd1 >= MAX_H) state_d = S_KO;
            end
            if (!bus.game_active) state_d = S_IDLE;
         end
         S_RECOVER: begin
            if (!bus.game_active) begin
               state_d = S_IDLE;
            end else if (cnt_zero) begin
               cnt_d   = IDLE_LD;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_KO: begin
            if (!bus.game_active) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         side_q    <= 1'b0;
         hits_q    <= '0;
         hit_q     <= 1'b0;
         dodged_q  <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         side_q    <= side_d;
         hits_q    <= hits_d;
         hit_q     <= hit_d;
         dodged_q  <= dodged_d;
         blocked_q <= blocked_d;
      end
   end

   assign bus.lfsr_enable   = (state_q == S_SAMPLE);
   assign bus.wind_up       = (state_q == S_WINDUP);
   assign bus.punch_side    = side_q & (state_q != S_IDLE);
   assign bus.punch_left    = (state_q == S_STRIKE) & ~side_q;
   assign bus.punch_right   = (state_q == S_STRIKE) & side_q;
   assign bus.player_hit    = hit_q;
   assign bus.punch_dodged  = dodged_q;
   assign bus.punch_blocked = blocked_q;
   assign bus.hits_taken    = hits_q;
   assign bus.ko            = (state_q == S_KO);

endmodule

// File: tb/tb_opponent_punch_ctrl.sv
// Directed bench for opponent_punch_ctrl with a scoreboard of expected punch outcomes.
// Cycle k is the interval after clock edge k-1, edge 0 being the one that first samples game_active.
module tb_opponent_punch_ctrl;

   localparam logic [2:0] OUT_HIT   = 3'b100;
   localparam logic [2:0] OUT_DODGE = 3'b010;
   localparam logic [2:0] OUT_BLOCK = 3'b001;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [6:0] exp_q[$];

   opponent_punch_ctrl_if bus();

   opponent_punch_ctrl #(
      .CNT_W(8), .IDLE_CYCLES(4), .WINDUP_CYCLES(3), .RECOVER_CYCLES(2), .MAX_HITS(3)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // From the STRIKE cycle: apply a response, queue the outcome, and step into the next cycle.
   task automatic respond(input logic dl, input logic dr, input logic blk,
                          input logic [2:0] outc, input logic [3:0] hits);
      bus.dodge_left  = dl;
      bus.dodge_right = dr;
      bus.block       = blk;
      exp_q.push_back({outc, hits});
      tick();
      bus.dodge_left  = 1'b0;
      bus.dodge_right = 1'b0;
      bus.block       = 1'b0;
   endtask

   task automatic restart();
      bus.game_active = 1'b0;
      tick();
      bus.game_active = 1'b1;
      tick();
   endtask

   // Scoreboard: any outcome pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (reset_n && (bus.player_hit || bus.punch_dodged || bus.punch_blocked)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {bus.player_hit, bus.punch_dodged, bus.punch_blocked}, 0);
         end else begin
            logic [6:0] e;
            e = exp_q.pop_front();
            chk("outcome", {bus.player_hit, bus.punch_dodged, bus.punch_blocked}, e[6:4]);
            chk("hits_at_outcome", bus.hits_taken, e[3:0]);
         end
      end
   end

   initial begin
      int bad;
      bus.game_active = 1'b0;
      bus.random_pos  = 1'b0;
      bus.dodge_left  = 1'b0;
      bus.dodge_right = 1'b0;
      bus.block       = 1'b0;

      #22;
      chk("reset_outputs", {bus.lfsr_enable, bus.wind_up, bus.punch_side, bus.punch_left,
          bus.punch_right, bus.player_hit, bus.punch_dodged, bus.punch_blocked,
          bus.hits_taken, bus.ko}, 0);
      reset_n = 1'b1;
      tick();
      chk("idle_no_lfsr", bus.lfsr_enable, 0);

      // Timing with a right punch
      bus.random_pos  = 1'b1;
      bus.game_active = 1'b1;
      tick();
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("lfsr_en_c%0d", c), bus.lfsr_enable, (c == 5 || c == 16));
         chk($sformatf("wind_up_c%0d", c), bus.wind_up, (c >= 6 && c <= 8));
         chk($sformatf("punch_r_c%0d", c), bus.punch_right, (c == 9));
         chk($sformatf("punch_l_c%0d", c), bus.punch_left, 0);
         if (c == 8) chk("side_right", bus.punch_side, 1);
         if (c == 9) exp_q.push_back({OUT_HIT, 4'd1});
         if (c < 16) tick();
      end

      // Left punch: correct dodge, wrong dodge, block beats dodge
      bus.random_pos = 1'b0;
      restart();
      ticks(8);
      chk("punch_left_strike", bus.punch_left, 1);
      respond(1'b0, 1'b1, 1'b0, OUT_DODGE, 4'd0);
      tick();
      chk("dodge_one_cycle", bus.punch_dodged, 0);
      chk("hits_after_dodge", bus.hits_taken, 0);
      ticks(9);
      chk("punch_left_2", bus.punch_left, 1);
      respond(1'b1, 1'b0, 1'b0, OUT_HIT, 4'd1);
      ticks(10);
      chk("punch_left_3", bus.punch_left, 1);
      respond(1'b1, 1'b0, 1'b1, OUT_BLOCK, 4'd1);
      chk("hits_after_block", bus.hits_taken, 1);

      // KO after three unanswered punches
      restart();
      ticks(8);
      respond(1'b0, 1'b0, 1'b0, OUT_HIT, 4'd1);
      ticks(10);
      respond(1'b0, 1'b0, 1'b0, OUT_HIT, 4'd2);
      ticks(10);
      chk("ko_before_third", bus.ko, 0);
      respond(1'b0, 1'b0, 1'b0, OUT_HIT, 4'd3);
      chk("ko_set", bus.ko, 1);
      chk("hits_ko", bus.hits_taken, 3);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.lfsr_enable || !bus.ko || bus.wind_up || bus.hits_taken != 4'd3) bad++;
      end
      chk("ko_hold_50", bad, 0);
      bus.game_active = 1'b0;
      tick();
      chk("ko_clear_idle", bus.ko, 0);
      chk("hits_held_idle", bus.hits_taken, 3);
      bus.game_active = 1'b1;
      tick();
      chk("hits_cleared_start", bus.hits_taken, 0);

      // Abort during WINDUP
      ticks(5);
      chk("abort_windup_on", bus.wind_up, 1);
      bus.game_active = 1'b0;
      tick();
      chk("abort_windup_off", bus.wind_up, 0);
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.punch_left || bus.punch_right || bus.lfsr_enable || bus.wind_up) bad++;
      end
      chk("abort_no_punch", bad, 0);

      // Asynchronous reset mid-WINDUP after a hit
      bus.random_pos = 1'b1;
      bus.game_active = 1'b1;
      tick();
      ticks(8);
      respond(1'b0, 1'b0, 1'b0, OUT_HIT, 4'd1);
      ticks(7);
      chk("pre_reset_windup", bus.wind_up, 1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", {bus.lfsr_enable, bus.wind_up, bus.punch_side, bus.punch_left,
          bus.punch_right, bus.player_hit, bus.punch_dodged, bus.punch_blocked,
          bus.hits_taken, bus.ko}, 0);
      repeat (2) @(posedge clock);
      #3;
      reset_n = 1'b1;
      tick();
      for (int c = 1; c <= 5; c++) begin
         chk($sformatf("post_reset_lfsr_c%0d", c), bus.lfsr_enable, (c == 5));
         if (c < 5) tick();
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/opponent_punch_ctrl.md
Name: opponent_punch_ctrl

Overview:
- Opponent attack sequencer for the Punch-Out game. It consumes the 1-bit pseudorandom stream from the LFSR and runs each opponent punch through wait, wind-up, strike and recover phases.
- It owns the LFSR's enable. Enable stays low while idle so the LFSR can take its seed. It pulses enable high for exactly one cycle per punch to draw one random bit.
- It judges the player's dodge/block response, counts hits taken, and flags KO to the game-level control and drawing logic.

Parameters:
- CNT_W, 26, width of the phase down-counter.
- IDLE_CYCLES, 25000000, cycles spent in WAIT before each punch (0.5 s at 50 MHz); must be ≥1.
- WINDUP_CYCLES, 15000000, cycles of visible wind-up telegraph; must be ≥1.
- RECOVER_CYCLES, 10000000, cycles after the strike before the next WAIT; must be ≥1.
- MAX_HITS, 3, hits that cause KO; 1..15.

Ports:
- clock  in  1  system clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- game_active  in  1  level; high while a round is in progress.
- random_pos  in  1  combinational random bit from the LFSR.
- dodge_left  in  1  player dodging left (level, synchronous to clock).
- dodge_right  in  1  player dodging right.
- block  in  1  player blocking.
- lfsr_enable  out  1  LFSR step request; high for exactly one cycle, in SAMPLE only.
- wind_up  out  1  high throughout WINDUP.
- punch_side  out  1  0 = left, 1 = right; latched in SAMPLE and held until the next SAMPLE.
- punch_left  out  1  high in STRIKE when punch_side = 0.
- punch_right  out  1  high in STRIKE when punch_side = 1.
- player_hit  out  1  one-cycle pulse.
- punch_dodged  out  1  one-cycle pulse.
- punch_blocked  out  1  one-cycle pulse.
- hits_taken  out  4  hit count, saturating at MAX_HITS.
- ko  out  1  high in the KO state.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - State goes to IDLE.
  - Counter, punch_side and hits_taken go to 0.
  - All outputs are 0 immediately, including mid-punch.
- States: IDLE, WAIT, SAMPLE, WINDUP, STRIKE, RECOVER, KO. Outputs are Moore decodes of state or registered values; there is no combinational path from input to output.
- IDLE:
  - All outputs are 0 except hits_taken, which holds its value.
  - If game_active = 1 at an edge: hits_taken is cleared, the counter is loaded with IDLE_CYCLES-1, and the next state is WAIT.
- WAIT: decrement the counter; when it is 0 at an edge, go to SAMPLE. WAIT lasts exactly IDLE_CYCLES cycles.
- SAMPLE:
  - lfsr_enable = 1 for this single cycle.
  - At the closing edge, punch_side <= random_pos. This is the pre-shift value, read in the same cycle the LFSR is enabled.
  - Load the counter with WINDUP_CYCLES-1 and go to WINDUP.
- WINDUP: wind_up = 1; count down; at 0, go to STRIKE. Lasts WINDUP_CYCLES cycles.
- STRIKE: one cycle; punch_left/punch_right asserted per punch_side. At the closing edge, the outcome is judged with this priority:
  - block = 1 → blocked.
  - Otherwise, correct dodge → dodged. A left punch is dodged by dodge_right=1, dodge_left=0; a right punch by dodge_left=1, dodge_right=0.
  - Otherwise → hit. A wrong-direction dodge, both dodges high, or no input all count as a hit.
  - On a hit, hits_taken increments.
- Outcome pulse:
  - The matching pulse is registered and high only in the first cycle after STRIKE; exactly one of the three pulses fires per punch.
  - If the hit makes hits_taken = MAX_HITS, the next state is KO. Otherwise the counter is loaded with RECOVER_CYCLES-1 and the next state is RECOVER.
- RECOVER: count down; at 0, reload with IDLE_CYCLES-1 and go to WAIT.
- Punch period: IDLE_CYCLES + WINDUP_CYCLES + RECOVER_CYCLES + 2 cycles.
- KO:
  - ko = 1; lfsr_enable, wind_up and punches stay 0; hits_taken is held.
  - Leave only when game_active = 0, going to IDLE.
- game_active = 0 at any edge in WAIT..RECOVER: go to IDLE. Outputs clear on the next cycle, except any pulse already registered from STRIKE. hits_taken is retained until the next start.
- hits_taken never exceeds MAX_HITS. The counter is never loaded with a negative value; the parameter minimums guarantee this.

Test Plan (all with IDLE_CYCLES=4, WINDUP_CYCLES=3, RECOVER_CYCLES=2, MAX_HITS=3; game_active raised and sampled at edge 0):
- Timing, random_pos=1:
  - WAIT in cycles 1-4; lfsr_enable=1 only in cycle 5.
  - wind_up=1 in cycles 6-8 with punch_side=1; punch_right=1 only in cycle 9.
  - Outcome pulse in cycle 10; next lfsr_enable in cycle 16.
- Left punch (random_pos=0), dodge_right=1 in STRIKE → punch_dodged=1 for 1 cycle, hits_taken stays 0. Repeat with dodge_left=1 → player_hit=1, hits_taken=1.
- block=1 together with dodge_left=1 against a left punch → punch_blocked only; hits_taken unchanged.
- KO sequence:
  - Three unanswered punches → hits_taken=3, and ko=1 from the cycle after the third STRIKE.
  - lfsr_enable stays 0 for 50 further cycles.
  - Drop game_active → IDLE, ko=0. Re-raise it → hits_taken=0.
- Abort and reset:
  - Drop game_active during WINDUP → wind_up=0 the next cycle; no punch or pulse follows.
  - Pull reset_n low mid-WINDUP, between clock edges → all outputs 0 immediately.
  - After reset_n releases with game_active=1 held → the first lfsr_enable comes 5 cycles after the first edge.
